// File: rtl/layer_tm.sv
// layer_tm: time-multiplexed fully-connected layer.
//   layer_out[j] = sat(round(bias[j] + sum_k x[k]*weights[k][j])) computed with
//   NUM_PE shared MAC lanes over ceil(NUM_CLASSES/NUM_PE) feature-serial passes.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      run request, accepted only in IDLE
//   x          F signed words, x[k] = x[k*W +: W], latched on accept
//   bias       C signed words, bias[j] = bias[j*W +: W]
//   weights    F*C signed words, weights[k][j] = weights[(k*C+j)*W +: W]
//   layer_out  C registered signed results, updated only on done
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle pulse when layer_out is updated
//   sat        sticky: some output of the last run was clamped
// Build option: define LAYER_TM_RELU_EN to clamp negative results to zero
//   after saturation (sat is not affected by the ReLU clamp).
module layer_tm #(
   parameter int unsigned NUM_FEATURES  = 4,
   parameter int unsigned NUM_CLASSES   = 3,
   parameter int unsigned NUM_PE        = 2,
   parameter int unsigned FP_TOTAL_BITS = 16,
   parameter int unsigned FP_FRAC_BITS  = 8
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 start,
   input  logic [FP_TOTAL_BITS*NUM_FEATURES-1:0]                x,
   input  logic [FP_TOTAL_BITS*NUM_CLASSES-1:0]                 bias,
   input  logic [FP_TOTAL_BITS*NUM_FEATURES*NUM_CLASSES-1:0]    weights,
   output logic [FP_TOTAL_BITS*NUM_CLASSES-1:0]                 layer_out,
   output logic                                                 busy,
   output logic                                                 done,
   output logic                                                 sat
);

   localparam int unsigned W   = FP_TOTAL_BITS;
   localparam int unsigned Q   = FP_FRAC_BITS;
   localparam int unsigned F   = NUM_FEATURES;
   localparam int unsigned C   = NUM_CLASSES;
   localparam int unsigned PE  = NUM_PE;
   localparam int unsigned P   = (C + PE - 1) / PE;
   localparam int unsigned AW  = 2 * W + $clog2(F) + 1;
   localparam int unsigned TW  = AW + 1;
   localparam int unsigned KW  = (F > 1) ? $clog2(F) : 1;
   localparam int unsigned PW  = (P > 1) ? $clog2(P) : 1;

   localparam logic [KW-1:0]        K_LAST = KW'(F - 1);
   localparam logic [PW-1:0]        P_LAST = PW'(P - 1);
   localparam logic [TW-1:0]        RND    = TW'(1) << (Q - 1);
   localparam logic signed [TW-1:0] MAX_V  = {{(TW - W + 1){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [TW-1:0] MIN_V  = {{(TW - W + 1){1'b1}}, {(W - 1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

   state_t                 state;
   logic [W*F-1:0]         x_lat;
   logic [KW-1:0]          k_cnt;
   logic [PW-1:0]          p_cnt;
   logic signed [AW-1:0]   acc [PE];
   logic [W*C-1:0]         res_buf;
   logic                   sat_acc;

   // Per-lane datapath: current product and finalised (rounded, clamped) result
   logic signed [W-1:0]    x_k;
   int unsigned            j_l    [PE];
   logic signed [W-1:0]    w_l    [PE];
   logic signed [W-1:0]    b_l    [PE];
   logic signed [2*W-1:0]  prod   [PE];
   logic signed [TW-1:0]   t_l    [PE];
   logic signed [TW-1:0]   r_l    [PE];
   logic [W-1:0]           y_l    [PE];
   logic                   s_l    [PE];
   logic [W*C-1:0]         buf_next;
   logic                   lane_sat_any;

   // Lane operand select, MAC product, finalise and merge into buffer image
   always_comb begin
      x_k          = x_lat[32'(k_cnt) * W +: W];
      buf_next     = res_buf;
      lane_sat_any = 1'b0;
      for (int i = 0; i < int'(PE); i++) begin
         j_l[i] = 32'(p_cnt) * PE + 32'(i);
         w_l[i] = '0;
         b_l[i] = '0;
         // Lanes past the last class run on zero operands and are discarded
         if (j_l[i] < C) begin
            w_l[i] = weights[(32'(k_cnt) * C + j_l[i]) * W +: W];
            b_l[i] = bias[j_l[i] * W +: W];
         end
         prod[i] = x_k * w_l[i];
         t_l[i]  = {acc[i][AW-1], acc[i]}
                 + ({{(TW - W){b_l[i][W-1]}}, b_l[i]} << Q)
                 + RND;
         r_l[i]  = t_l[i] >>> Q;
         s_l[i]  = 1'b0;
         if (r_l[i] > MAX_V) begin
            y_l[i] = {1'b0, {(W - 1){1'b1}}};
            s_l[i] = 1'b1;
         end else if (r_l[i] < MIN_V) begin
            y_l[i] = {1'b1, {(W - 1){1'b0}}};
            s_l[i] = 1'b1;
         end else begin
            y_l[i] = r_l[i][W-1:0];
         end
`ifdef LAYER_TM_RELU_EN
         if (y_l[i][W-1]) y_l[i] = '0;
`endif
         if (j_l[i] < C) begin
            buf_next[j_l[i] * W +: W] = y_l[i];
            lane_sat_any = lane_sat_any | s_l[i];
         end
      end
   end

   // Control FSM and all registered state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         x_lat     <= '0;
         k_cnt     <= '0;
         p_cnt     <= '0;
         for (int i = 0; i < int'(PE); i++) acc[i] <= '0;
         res_buf   <= '0;
         sat_acc   <= 1'b0;
         layer_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sat       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_lat   <= x;
                  sat_acc <= 1'b0;
                  k_cnt   <= '0;
                  p_cnt   <= '0;
                  for (int i = 0; i < int'(PE); i++) acc[i] <= '0;
                  busy    <= 1'b1;
                  state   <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               for (int i = 0; i < int'(PE); i++)
                  acc[i] <= acc[i] + {{(AW - 2 * W){prod[i][2*W-1]}}, prod[i]};
               if (k_cnt == K_LAST) begin
                  k_cnt <= '0;
                  state <= S_WRITE;
               end else begin
                  k_cnt <= k_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               res_buf <= buf_next;
               sat_acc <= sat_acc | lane_sat_any;
               if (p_cnt == P_LAST) begin
                  // Publish results so they appear together with done
                  layer_out <= buf_next;
                  sat       <= sat_acc | lane_sat_any;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  p_cnt <= p_cnt + 1'b1;
                  for (int i = 0; i < int'(PE); i++) acc[i] <= '0;
                  state <= S_ACCUM;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
